div_unit: RTL



---
 rtl/div_unit.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/div_unit.sv
// div_unit: sequential unsigned restoring divider (2*DATA_WIDTH / DATA_WIDTH), one quotient bit per clock.
// Latency: out_valid rises 2*DATA_WIDTH edges after the accept edge (after the accept edge itself for divisor 0 when DIV_UNIT_DBZ_EN is defined).
// Backpressure: in_ready only in IDLE; the result is held in DONE until out_ready, and no new operands are taken on the handshake edge.
module div_unit #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [2*DATA_WIDTH-1:0] dividend,
    input  logic [DATA_WIDTH-1:0]   divisor,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [2*DATA_WIDTH-1:0] quotient,
    output logic [DATA_WIDTH-1:0]   remainder,
    output logic                    dbz
);

    localparam int DW  = DATA_WIDTH;
    localparam int DW2 = 2 * DATA_WIDTH;
    localparam int CW  = $clog2(DW2 + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          state_q, state_d;
    // a_q shifts dividend bits out of the top while quotient bits enter at the bottom
    logic [DW2-1:0]  a_q, a_d;
    logic [DW-1:0]   b_q, b_d;
    logic [DW-1:0]   rem_q, rem_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            in_ready_q, in_ready_d;
    logic            out_valid_q, out_valid_d;
    logic [DW2-1:0]  quot_q, quot_d;
    logic [DW-1:0]   remo_q, remo_d;
    logic            dbz_q, dbz_d;

    logic            accept;
    logic            res_take;
    logic            div_zero;
    logic            last_iter;
    logic [DW:0]     trial;
    logic [DW:0]     diff;
    logic [DW:0]     rem_next;
    logic            ge;
    logic            unused_rem_msb;

    assign accept    = in_valid && in_ready_q;
    assign res_take  = out_valid_q && out_ready;
    assign last_iter = (cnt_q == CW'(1));

`ifdef DIV_UNIT_DBZ_EN
    assign div_zero = (divisor == '0);
`else
    assign div_zero = 1'b0;
`endif

    // W+1-bit partial remainder: previous remainder shifted left with the next dividend MSB
    assign trial    = {rem_q, a_q[DW2-1]};
    assign ge       = (trial >= {1'b0, b_q});
    assign diff     = trial - {1'b0, b_q};
    assign rem_next = ge ? diff : trial;
    // Top bit only matters for the compare of the current step; it never reaches the next trial or the result
    assign unused_rem_msb = rem_next[DW];

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)    state_d = div_zero ? DONE : BUSY;
            BUSY:    if (last_iter) state_d = DONE;
            DONE:    if (res_take)  state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    // Output flags are registered copies of the upcoming state
    always_comb begin
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    // Datapath next-state: operand capture, one restoring step per BUSY cycle, result latch
    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        rem_d  = rem_q;
        cnt_d  = cnt_q;
        quot_d = quot_q;
        remo_d = remo_q;
        dbz_d  = dbz_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    a_d   = dividend;
                    b_d   = divisor;
                    rem_d = '0;
                    cnt_d = CW'(DW2);
                    if (div_zero) begin
                        quot_d = '1;
                        remo_d = dividend[DW-1:0];
                        dbz_d  = 1'b1;
                    end
                end
            end
            BUSY: begin
                a_d   = {a_q[DW2-2:0], ge};
                rem_d = rem_next[DW-1:0];
                cnt_d = cnt_q - CW'(1);
                if (last_iter) begin
                    quot_d = {a_q[DW2-2:0], ge};
                    remo_d = rem_next[DW-1:0];
                    dbz_d  = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // Datapath and output registers; reset drops any in-flight operation
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q         <= '0;
            b_q         <= '0;
            rem_q       <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            quot_q      <= '0;
            remo_q      <= '0;
            dbz_q       <= 1'b0;
        end else begin
            a_q         <= a_d;
            b_q         <= b_d;
            rem_q       <= rem_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            quot_q      <= quot_d;
            remo_q      <= remo_d;
            dbz_q       <= dbz_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign quotient  = quot_q;
    assign remainder = remo_q;
    assign dbz       = dbz_q;

endmodule
